// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (port 0) and load (port 1) writeback.
// One-cycle latency from accept edge to rf_*; rf_stall blocks both readies and freezes all state.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rf_stall,
  output logic              sel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic              last_grant_q, last_grant_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              contended;
  logic              grant0, grant1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  assign contended = req0_valid && req1_valid;

  // On a tie the port that did not win last time goes; last_grant resets to 1 so port 0 takes the first tie.
  assign grant0 = !rf_stall && req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = !rf_stall && req1_valid && (!req0_valid || !last_grant_q);

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign win_addr = grant1 ? req1_addr : req0_addr;
  assign win_data = grant1 ? req1_data : req0_data;

  always_comb begin
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    we_d         = we_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    if (!rf_stall) begin
      if (grant0 || grant1) begin
        last_grant_d = grant1;
        sel_d        = grant1;
        waddr_d      = win_addr;
        wdata_d      = win_data;
        // Register 0 is hardwired: the handshake completes but the write is dropped.
        we_d         = (win_addr != '0);
      end else begin
        we_d = 1'b0;
      end
      if (contended && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sel          = sel_q;
  assign rf_we        = we_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: vector table plus a saturation sequence, post-edge outputs checked via a queue.
module tb_wb_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, rf_stall;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          sel, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_stall(rf_stall), .sel(sel), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .conflict_cnt(conflict_cnt)
  );

  typedef struct packed {
    logic          sel;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [CW-1:0] cnt;
  } out_t;

  typedef struct {
    logic          rst_n, stall;
    logic          v0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          chk_rdy, r0, r1;
    out_t          exp;
  } vec_t;

  out_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(input logic rs, input logic st,
                              input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                              input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                              input logic chk, input logic r0, input logic r1,
                              input logic es, input logic ew, input logic [AW-1:0] ea,
                              input logic [DW-1:0] ed, input logic [CW-1:0] ec);
    vec_t v;
    v.rst_n = rs; v.stall = st;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.chk_rdy = chk; v.r0 = r0; v.r1 = r1;
    v.exp.sel = es; v.exp.we = ew; v.exp.waddr = ea; v.exp.wdata = ed; v.exp.cnt = ec;
    return v;
  endfunction

  task automatic step(input vec_t v, input string name);
    out_t got, want;
    @(negedge clk);
    rst_n = v.rst_n; rf_stall = v.stall;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    #1;
    if (v.chk_rdy) begin
      tests++;
      if ({req0_ready, req1_ready} !== {v.r0, v.r1}) begin
        fails++;
        $display("FAIL rdy %s: got r0=%b r1=%b want r0=%b r1=%b", name, req0_ready, req1_ready, v.r0, v.r1);
      end
    end
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    got = {sel, rf_we, rf_waddr, rf_wdata, conflict_cnt};
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL out %s: scoreboard empty", name);
    end else begin
      want = sb.pop_front();
      if (got !== want) begin
        fails++;
        $display("FAIL out %s: got sel=%b we=%b a=%0d d=%h cnt=%0d want sel=%b we=%b a=%0d d=%h cnt=%0d",
                 name, got.sel, got.we, got.waddr, got.wdata, got.cnt,
                 want.sel, want.we, want.waddr, want.wdata, want.cnt);
      end
    end
  endtask

  localparam logic [DW-1:0] DA = 32'hA;
  localparam logic [DW-1:0] DB = 32'hB;

  initial begin
    vec_t tbl[17];
    logic lg;
    logic g;
    logic [CW-1:0] cnt;

    rst_n = 1'b0; rf_stall = 1'b0;
    req0_valid = 1'b1; req0_addr = 5; req0_data = DA;
    req1_valid = 1'b1; req1_addr = 7; req1_data = DB;

    //             rst st  v0 a0 d0  v1 a1 d1       chk r0 r1  sel we addr data  cnt
    tbl[0]  = mk(0, 0, 1, 5, DA, 1, 7, DB,        0, 0, 0,  0, 0, 0, 0,     0);
    tbl[1]  = mk(0, 0, 1, 5, DA, 1, 7, DB,        0, 0, 0,  0, 0, 0, 0,     0);
    tbl[2]  = mk(1, 0, 1, 5, DA, 1, 7, DB,        1, 1, 0,  0, 1, 5, DA,    1);
    tbl[3]  = mk(1, 0, 1, 5, DA, 1, 7, DB,        1, 0, 1,  1, 1, 7, DB,    2);
    tbl[4]  = mk(1, 0, 1, 5, DA, 1, 7, DB,        1, 1, 0,  0, 1, 5, DA,    3);
    tbl[5]  = mk(1, 0, 1, 5, DA, 1, 7, DB,        1, 0, 1,  1, 1, 7, DB,    4);
    tbl[6]  = mk(1, 0, 0, 5, DA, 1, 0, 32'hFFFF,  1, 0, 1,  1, 0, 0, 32'hFFFF, 4);
    tbl[7]  = mk(1, 0, 1, 5, DA, 1, 7, DB,        1, 1, 0,  0, 1, 5, DA,    5);
    tbl[8]  = mk(1, 1, 1, 5, DA, 1, 7, DB,        1, 0, 0,  0, 1, 5, DA,    5);
    tbl[9]  = mk(1, 1, 1, 5, DA, 1, 7, DB,        1, 0, 0,  0, 1, 5, DA,    5);
    tbl[10] = mk(1, 1, 1, 5, DA, 1, 7, DB,        1, 0, 0,  0, 1, 5, DA,    5);
    tbl[11] = mk(1, 0, 1, 5, DA, 1, 7, DB,        1, 0, 1,  1, 1, 7, DB,    6);
    tbl[12] = mk(1, 0, 0, 5, DA, 0, 7, DB,        1, 0, 0,  1, 0, 7, DB,    6);
    tbl[13] = mk(1, 0, 1, 3, 32'h33, 0, 7, DB,    1, 1, 0,  0, 1, 3, 32'h33, 6);
    tbl[14] = mk(0, 0, 1, 5, DA, 1, 7, DB,        0, 0, 0,  0, 0, 0, 0,     0);
    tbl[15] = mk(1, 0, 1, 5, DA, 1, 7, DB,        1, 1, 0,  0, 1, 5, DA,    1);
    tbl[16] = mk(1, 0, 0, 9, 32'h99, 1, 4, 32'h44, 1, 0, 1, 1, 1, 4, 32'h44, 1);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end

    // 20 contended cycles from cnt=1, last winner port 1: grants alternate, count pins at 15.
    lg = 1'b1;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      g = ~lg;
      cnt = (cnt == 4'hF) ? cnt : cnt + 1'b1;
      step(mk(1, 0, 1, 5, DA, 1, 7, DB, 1, ~g, g, g, 1, g ? 5'd7 : 5'd5, g ? DB : DA, cnt),
           $sformatf("sat%0d", i));
      lg = g;
    end

    step(mk(1, 1, 1, 5, DA, 1, 7, DB, 1, 0, 0, lg, 1, lg ? 5'd7 : 5'd5, lg ? DB : DA, 4'hF), "sat_stall");
    step(mk(0, 0, 0, 5, DA, 0, 7, DB, 0, 0, 0, 0, 0, 0, 0, 0), "final_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port 0 (ALU result) and port 1 (load result).
- Arbitrates between them round-robin and registers the winning write.
- Drives the select line of the 5-bit destination-register 2:1 mux and the matching data mux, plus the register-file write enable.
- Sits between the EX/MEM writeback sources and the register file.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 5, width of register address (32 registers).
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req0_valid  input  1  port 0 has a write pending.
- req0_addr  input  ADDR_W  port 0 destination register.
- req0_data  input  DATA_W  port 0 write data.
- req0_ready  output  1  port 0 write accepted this cycle.
- req1_valid  input  1  port 1 has a write pending.
- req1_addr  input  ADDR_W  port 1 destination register.
- req1_data  input  DATA_W  port 1 write data.
- req1_ready  output  1  port 1 write accepted this cycle.
- rf_stall  input  1  register file cannot take a write this cycle.
- sel  output  1  registered mux select: 0 = port 0, 1 = port 1.
- rf_we  output  1  registered write enable.
- rf_waddr  output  ADDR_W  registered write address.
- rf_wdata  output  DATA_W  registered write data.
- conflict_cnt  output  CNT_W  count of contended cycles, saturating.

Behaviour:
- State:
  - last_grant (1 bit).
  - Output register {sel, rf_we, rf_waddr, rf_wdata}.
  - conflict_cnt.
- Reset (rst_n=0 at a clock edge):
  - sel=0, rf_we=0, rf_waddr=0, rf_wdata=0, conflict_cnt=0, last_grant=1.
  - Reset mid-operation discards any registered write: rf_we=0 from the next cycle.
- Handshake:
  - A transfer occurs on reqN_valid && reqN_ready at a clock edge.
  - ready is combinational from valid, last_grant and rf_stall.
  - At most one ready is high per cycle.
  - A requester holds valid, addr and data stable until its ready is seen.
- Grant rule when rf_stall=0:
  - Only port 0 valid -> grant 0.
  - Only port 1 valid -> grant 1.
  - Both valid -> grant the port != last_grant; the first tie after reset goes to port 0.
  - Neither valid -> no grant.
- rf_stall=1:
  - Both readies are 0.
  - Output register, last_grant and conflict_cnt hold.
- On a grant (the edge at which the transfer occurs):
  - last_grant <= granted port; sel <= granted port.
  - rf_waddr <= granted addr; rf_wdata <= granted data.
  - rf_we <= (granted addr != 0).
- Writes to register 0:
  - The handshake completes and round-robin advances.
  - The write is dropped: rf_we=0.
- Latency: a write accepted at edge k appears on rf_* during cycle k+1 (one cycle).
- No grant with rf_stall=0: rf_we <= 0; sel, rf_waddr, rf_wdata hold their previous values.
- Back-to-back: one write accepted per unstalled cycle. The output register drains every unstalled cycle, so no internal buffering beyond one entry.
- Same-address contention on both ports: no special handling. Winner per round-robin; loser writes the next cycle, so the later write wins in the register file.
- conflict_cnt:
  - Increments by 1 in each cycle with req0_valid && req1_valid && !rf_stall.
  - Saturates at 2^CNT_W-1; no wrap.
- Fairness bound: a continuously valid port is granted within 2 unstalled cycles.

Test Plan:
- Reset with both valid held -> first cycle after reset: rf_we=0, sel=0; first unstalled tie grants port 0 (req0_ready=1, req1_ready=0).
- Both ports valid for 4 cycles, addr0=5/data0=0xA, addr1=7/data1=0xB, rf_stall=0 -> grants 0,1,0,1. rf_* one cycle later: (sel 0, 5, 0xA), (sel 1, 7, 0xB), ... with rf_we=1 throughout; conflict_cnt=4.
- Port 1 only, addr=0, data=0xFFFF -> req1_ready=1; next cycle rf_we=0; last_grant=1, so a following tie grants port 0.
- rf_stall=1 for 3 cycles with both valid -> both readies 0; rf_* and conflict_cnt unchanged. On release, the grant follows the pre-stall last_grant.
- Force conflict_cnt to saturate (CNT_W=4, 20 contended cycles) -> holds at 15.
- Assert rst_n=0 the cycle after a grant of addr=3 -> rf_we=0 next cycle, conflict_cnt=0, and the next tie grants port 0.
